uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- 8N1 UART receiver that turns the raw UART_RXD pin into framed bytes with a valid/ack handshake.
- Sits between the board pin and the processor's memory-mapped serial input, directly upstream of albacore_mem_io's receive path.
- Provides metastability synchronisation, mid-bit sampling, framing-error detection, and a one-entry holding register with overrun flag, so software may poll at leisure.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (434), clocks per bit period; overridable directly for simulation; legal range is 4 or more.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level); single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line; idles high.
- rx_data  out  8  last received byte; stable while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ack  in  1  consumer pop; effective only when rx_valid=1.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  sticky flag: a byte completed while the holding register was full and not being acked.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counters=0, both synchroniser flops=1, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0. Reset mid-frame abandons the frame without producing a frame_err.
- Synchroniser: 2 flops; rxs is the second flop. All decisions use rxs; the pin-to-rxs latency is 2 cycles.
- H = (CLKS_PER_BIT-1)/2, integer division. The bit counter is clog2(CLKS_PER_BIT) bits wide.
- T0 is the first clk cycle with rxs=0 while state=IDLE.
- IDLE: rxs=0 -> START, counter cleared.
- START: at T0+H, sample rxs.
  - rxs=0 -> DATA, bit index=0, counter cleared.
  - rxs=1 -> IDLE (glitch rejected; no output change).
- DATA: bit i (i=0..7, LSB first) is sampled at T0+H+(i+1)*CLKS_PER_BIT and shifted in. After bit 7 -> STOP.
- STOP: sample at T0+H+9*CLKS_PER_BIT.
  - rxs=1 -> deliver the byte and go to IDLE.
  - rxs=0 -> frame_err=1 for exactly one cycle, byte discarded, go to BREAK.
- BREAK: wait for rxs=1, then IDLE. A line held low never produces further frames.
- Delivery (registered): rx_data and rx_valid update in the cycle after the stop sample.
  - rx_valid=0 -> load the byte, rx_valid=1.
  - rx_valid=1 and rx_ack=1 in the delivery cycle -> load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ack=0 -> new byte discarded, old rx_data kept, overrun=1.
- Ack: rx_ack with rx_valid=1 clears rx_valid next cycle and clears overrun. rx_ack with rx_valid=0 is ignored.
- rx_data holds its value after the ack until the next delivery.
- A new start bit is accepted from the cycle STOP returns to IDLE, so back-to-back frames with a single stop bit are received.

Decomposition:
- Package uart_pkg:
  - state encodings IDLE/START/DATA/STOP/BREAK (3-bit);
  - clog2 constant function;
  - default CLK_HZ/BAUD constants, shared with the future transmitter.
- One sub-module: sync_2ff (parameterised reset value, set to 1 here). It is reused for the button inputs where needed.

Test Plan (bench uses CLKS_PER_BIT=16, so H=7):
- Frame 0x55 with a valid stop bit -> rx_valid rises the cycle after T0+151; rx_data=0x55; frame_err=0; overrun=0.
- Low glitch of 4 cycles on the idle line -> state returns to IDLE at T0+7; no rx_valid, no frame_err.
- Frame 0xA3 with stop bit forced 0, line held low 40 further cycles, then high -> one frame_err pulse; rx_valid stays 0; next frame 0x3C is received correctly.
- Two back-to-back frames 0x12, 0x34 with no ack -> rx_data=0x12, rx_valid=1, overrun=1; after rx_ack, rx_valid=0 and overrun=0.
- Ack asserted in the exact delivery cycle of a second byte 0x77 -> rx_valid stays 1, rx_data=0x77, overrun=0.
- Reset asserted during DATA bit 4 of frame 0xFF, released, then frame 0x81 sent -> only 0x81 is delivered; no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and clog2 helper
package uart_pkg;

   localparam int DEFAULT_CLK_HZ = 50_000_000;
   localparam int DEFAULT_BAUD   = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with a parameterised reset value
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with mid-bit sampling and a one-entry holding register
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = DEFAULT_CLK_HZ,
   parameter int BAUD         = DEFAULT_BAUD,
   parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       frame_err,
   output logic       overrun
);

   localparam int                CNT_W     = clog2(CLKS_PER_BIT);
   localparam int                HALF      = (CLKS_PER_BIT - 1) / 2;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic             w_rxs;
   rx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_frame_err;
   logic             r_overrun;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (rx_serial),
      .o_sync  (w_rxs)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (rx_ack && r_valid) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (!w_rxs) begin
                  r_state <= ST_START;
                  r_cnt   <= '0;
               end
            end
            ST_START: begin
               // Mid start bit: a line that is already high again was a glitch.
               if (r_cnt == HALF_LAST) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= w_rxs ? ST_IDLE : ST_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (r_cnt == BIT_LAST) begin
                  r_cnt     <= '0;
                  r_shift   <= {w_rxs, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= ST_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (r_cnt == BIT_LAST) begin
                  r_cnt <= '0;
                  if (w_rxs) begin
                     r_state <= ST_IDLE;
                     // An ack in this same cycle frees the slot for the new byte.
                     if (!r_valid || rx_ack) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               if (w_rxs) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - scoreboard bench for uart_rx_byte at 16 clocks per bit
module tb_uart_rx_byte;

   localparam int CPB = 16;
   localparam int H   = (CPB - 1) / 2;
   localparam int LAT = 3 + H + 9 * CPB;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       rx_serial = 1'b1;
   logic       rx_ack    = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t_start  = 0;
   int t_rise   = 0;
   int fe_count = 0;
   int n_deliv  = 0;
   logic [7:0] sb[$];
   logic       r_pv = 1'b0;
   logic       r_pa = 1'b0;

   uart_rx_byte #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_serial (rx_serial),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // A delivery is valid rising, or valid still high right after an effective ack.
   always @(negedge clk) begin
      if (frame_err) fe_count <= fe_count + 1;
      if (rx_valid && (!r_pv || r_pa)) begin
         n_deliv <= n_deliv + 1;
         if (!r_pv) t_rise <= cyc;
         if (sb.size() == 0) check_eq("sb_underflow", 32'(sb.size()), 32'd1);
         else check_eq("sb_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
      end
      r_pv <= rx_valid;
      r_pa <= rx_ack;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      rx_serial = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         wait_cyc(CPB);
      end
      rx_serial = stop_ok;
      wait_cyc(CPB);
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      wait_cyc(1);
      rx_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      wait_cyc(3);
      @(negedge clk);
      check_eq("rst_valid", rx_valid, 1'b0);
      check_eq("rst_data", rx_data, 8'h00);
      check_eq("rst_ferr", frame_err, 1'b0);
      check_eq("rst_ovr", overrun, 1'b0);
      wait_cyc(1);
      reset = 1'b0;
      wait_cyc(5);

      sb.push_back(8'h55);
      t_start = cyc;
      send_frame(8'h55, 1'b1);
      wait_cyc(4);
      @(negedge clk);
      check_eq("t1_latency", 32'(t_rise - t_start), 32'(LAT));
      check_eq("t1_valid", rx_valid, 1'b1);
      check_eq("t1_data", rx_data, 8'h55);
      check_eq("t1_ferr", 32'(fe_count), 32'd0);
      check_eq("t1_ovr", overrun, 1'b0);
      do_ack();
      check_eq("t1_ack_valid", rx_valid, 1'b0);
      check_eq("t1_hold_data", rx_data, 8'h55);

      wait_cyc(1);
      rx_serial = 1'b0;
      wait_cyc(4);
      rx_serial = 1'b1;
      wait_cyc(40);
      @(negedge clk);
      check_eq("t2_deliv", 32'(n_deliv), 32'd1);
      check_eq("t2_ferr", 32'(fe_count), 32'd0);
      check_eq("t2_valid", rx_valid, 1'b0);

      wait_cyc(1);
      send_frame(8'hA3, 1'b0);
      wait_cyc(40);
      @(negedge clk);
      check_eq("t3_ferr_pulse", 32'(fe_count), 32'd1);
      check_eq("t3_valid", rx_valid, 1'b0);
      wait_cyc(1);
      rx_serial = 1'b1;
      wait_cyc(20);
      sb.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_cyc(4);
      @(negedge clk);
      check_eq("t3_valid_next", rx_valid, 1'b1);
      check_eq("t3_data_next", rx_data, 8'h3C);
      check_eq("t3_ferr_once", 32'(fe_count), 32'd1);
      do_ack();

      wait_cyc(1);
      sb.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      wait_cyc(4);
      @(negedge clk);
      check_eq("t4_valid", rx_valid, 1'b1);
      check_eq("t4_data", rx_data, 8'h12);
      check_eq("t4_ovr", overrun, 1'b1);
      do_ack();
      check_eq("t4_ack_valid", rx_valid, 1'b0);
      check_eq("t4_ack_ovr", overrun, 1'b0);

      wait_cyc(1);
      sb.push_back(8'h66);
      send_frame(8'h66, 1'b1);
      sb.push_back(8'h77);
      t_start = cyc;
      fork
         send_frame(8'h77, 1'b1);
         begin
            wait_cyc(LAT - 1);
            rx_ack = 1'b1;
            wait_cyc(1);
            rx_ack = 1'b0;
         end
      join
      wait_cyc(2);
      @(negedge clk);
      check_eq("t5_valid", rx_valid, 1'b1);
      check_eq("t5_data", rx_data, 8'h77);
      check_eq("t5_ovr", overrun, 1'b0);
      do_ack();

      wait_cyc(1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            wait_cyc(5 * CPB + 8);
            reset = 1'b1;
            wait_cyc(3);
            reset = 1'b0;
         end
      join
      wait_cyc(10);
      @(negedge clk);
      check_eq("t6_valid", rx_valid, 1'b0);
      wait_cyc(1);
      sb.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      wait_cyc(4);
      @(negedge clk);
      check_eq("t6_valid_next", rx_valid, 1'b1);
      check_eq("t6_data", rx_data, 8'h81);
      check_eq("t6_ferr", 32'(fe_count), 32'd1);
      check_eq("t6_ovr", overrun, 1'b0);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      check_eq("deliv_total", 32'(n_deliv), 32'd6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
